ahb_lite_sn: RTL

//  Single-master AHB-Lite interconnect for NUM_SLV slaves with a parametrised address map.

---
 rtl/ahb_defs.sv | 28 ++
 rtl/ahb_default_slave.sv | 54 +++++
 rtl/ahb_lite_sn.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ahb_defs.sv
// ---------------------------------------------------------------------------
// ahb_defs
// Shared AHB-Lite encodings for the ahb_lite_sn interconnect:
//   HTRANS codes, HRESP codes, default-slave FSM state encoding and a small
//   helper that tells whether a transfer type carries data.
// ---------------------------------------------------------------------------
package ahb_defs;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // NONSEQ/SEQ are real transfers; IDLE/BUSY never need a response beyond OKAY.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Responds to accesses that hit no mapped region with the two-cycle AHB
// ERROR response (HREADY low + ERROR, then HREADY high + ERROR).
// Ports:
//   i_hclk, i_hresetn  clock, asynchronous active-low reset
//   i_accept           an unmapped NONSEQ/SEQ address phase is accepted now
//   o_hreadyout        ready output while this slave owns the data phase
//   o_hresp            response while this slave owns the data phase
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_defs::*;
(
    input  logic       i_hclk,
    input  logic       i_hresetn,
    input  logic       i_accept,
    output logic       o_hreadyout,
    output logic [1:0] o_hresp
);

    ds_state_e r_state;
    ds_state_e w_next;

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) r_state <= DS_IDLE;
        else            r_state <= w_next;
    end

    // ERR2 drives HREADY high, so a new unmapped transfer can be accepted
    // there and must restart the error pair without passing through IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            DS_IDLE: if (i_accept) w_next = DS_ERR1;
            DS_ERR1: w_next = DS_ERR2;
            DS_ERR2: w_next = i_accept ? DS_ERR1 : DS_IDLE;
            default: w_next = DS_IDLE;
        endcase
    end

    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = HRESP_OKAY;
        case (r_state)
            DS_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = HRESP_ERROR;
            end
            DS_ERR2: o_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sn.sv
// ---------------------------------------------------------------------------
// ahb_lite_sn
// Single-master AHB-Lite interconnect for NUM_SLV slaves.
//   - address decode to one-hot HSEL (lowest slot wins, REMAP aliases slot 0
//     onto slot 1), unmapped addresses go to a built-in default slave
//   - data-phase owner register and HRDATA/HRESP/HREADY return mux
//   - sticky decode-error capture (ERR_VALID/ERR_ADDR, cleared by ERR_CLR)
// Ports:
//   HRESETn, HCLK                     async active-low reset, clock
//   M_*                               master side address/control/data
//   HADDR..HWDATA, HREADY             broadcast to slaves
//   HSEL                              one-hot slave select (address phase)
//   HRDATA, HRESP, HREADYOUT          per-slave return paths, slot i packed
//   REMAP                             alias slot-0 region onto slot 1
//   ERR_VALID, ERR_ADDR, ERR_CLR      decode-error capture and clear
// ---------------------------------------------------------------------------
module ahb_lite_sn
    import ahb_defs::*;
#(
    parameter int                    NUM_SLV      = 4,
    parameter logic [16*NUM_SLV-1:0] P_HSEL_START = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [16*NUM_SLV-1:0] P_HSEL_SIZE  = {NUM_SLV{16'h0100}}
) (
    input  logic                   HRESETn,
    input  logic                   HCLK,
    input  logic [31:0]            M_HADDR,
    input  logic [1:0]             M_HTRANS,
    input  logic                   M_HWRITE,
    input  logic [2:0]             M_HSIZE,
    input  logic [2:0]             M_HBURST,
    input  logic [3:0]             M_HPROT,
    input  logic [31:0]            M_HWDATA,
    output logic [31:0]            M_HRDATA,
    output logic [1:0]             M_HRESP,
    output logic                   M_HREADY,
    output logic [31:0]            HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic [31:0]            HWDATA,
    output logic                   HREADY,
    output logic [NUM_SLV-1:0]     HSEL,
    input  logic [32*NUM_SLV-1:0]  HRDATA,
    input  logic [2*NUM_SLV-1:0]   HRESP,
    input  logic [NUM_SLV-1:0]     HREADYOUT,
    input  logic                   REMAP,
    output logic                   ERR_VALID,
    output logic [31:0]            ERR_ADDR,
    input  logic                   ERR_CLR
);

    logic [16:0]        w_page;
    logic [NUM_SLV-1:0] w_hit;
    logic [NUM_SLV-1:0] w_first;
    logic [NUM_SLV-1:0] w_hsel;
    logic               w_def;
    logic               w_hready;
    logic               w_err_acc;
    logic               w_ds_hready;
    logic [1:0]         w_ds_hresp;
    logic [NUM_SLV:0]   r_dsel;     // bit NUM_SLV = default slave
    logic               r_err_valid;
    logic [31:0]        r_err_addr;

    // ---------------- address decode ----------------
    // 17-bit compare so START+SIZE never wraps; SIZE=0 gives an empty range.
    assign w_page = {1'b0, M_HADDR[31:16]};

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
        logic [16:0] w_lo;
        logic [16:0] w_hi;
        assign w_lo     = {1'b0, P_HSEL_START[16*i +: 16]};
        assign w_hi     = w_lo + {1'b0, P_HSEL_SIZE[16*i +: 16]};
        assign w_hit[i] = (w_page >= w_lo) && (w_page < w_hi);
    end

    // Walk from the top so the lowest overlapping slot is the last to write.
    always_comb begin
        w_first = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_first    = '0;
                w_first[i] = 1'b1;
            end
        end
    end

    if (NUM_SLV >= 2) begin : g_remap
        always_comb begin
            w_hsel = w_first;
            if (REMAP && w_first[0]) begin
                w_hsel    = '0;
                w_hsel[1] = 1'b1;
            end
        end
    end else begin : g_noremap
        assign w_hsel = w_first;
    end

    assign w_def = ~|w_hsel;
    assign HSEL  = w_hsel;

    // ---------------- data-phase owner ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)      r_dsel <= {1'b1, {NUM_SLV{1'b0}}};
        else if (w_hready) r_dsel <= {w_def, w_hsel};
    end

    // ---------------- default slave ----------------
    assign w_err_acc = w_def & trans_active(M_HTRANS) & w_hready;

    ahb_default_slave u_def (
        .i_hclk      (HCLK),
        .i_hresetn   (HRESETn),
        .i_accept    (w_err_acc),
        .o_hreadyout (w_ds_hready),
        .o_hresp     (w_ds_hresp)
    );

    // ---------------- return mux ----------------
    always_comb begin
        M_HRDATA = '0;
        M_HRESP  = w_ds_hresp;
        w_hready = w_ds_hready;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_dsel[i]) begin
                M_HRDATA = HRDATA[32*i +: 32];
                M_HRESP  = HRESP[2*i +: 2];
                w_hready = HREADYOUT[i];
            end
        end
    end

    assign M_HREADY = w_hready;
    assign HREADY   = w_hready;

    // ---------------- broadcast ----------------
    assign HADDR  = M_HADDR;
    assign HTRANS = M_HTRANS;
    assign HWRITE = M_HWRITE;
    assign HSIZE  = M_HSIZE;
    assign HBURST = M_HBURST;
    assign HPROT  = M_HPROT;
    assign HWDATA = M_HWDATA;

    // ---------------- error capture ----------------
    // A clear in the same cycle as a new error re-arms and captures at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if (w_err_acc && (!r_err_valid || ERR_CLR)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= M_HADDR;
        end else if (ERR_CLR) begin
            r_err_valid <= 1'b0;
        end
    end

    assign ERR_VALID = r_err_valid;
    assign ERR_ADDR  = r_err_addr;

endmodule
